traffic_light_monitor: RTL

- Passive checker on the observing side of the Traffic_Light_Controller light buses: samples light_M1, light_M2, light_MT, light_S every clock.
- Flags illegal encodings, conflicting greens, illegal colour sequences and dwell-time violations; counts errors and completed M1 cycles.
- Instantiated beside the controller in simulation and in the top level as a safety watchdog. Never drives the lights.

---
 rtl/traffic_light_monitor.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// Passive safety watchdog for the traffic-light controller buses: checks encoding,
// right-of-way conflicts, colour sequencing and dwell times; never drives the lights.
module traffic_light_monitor #(
  parameter int unsigned YELLOW_MIN = 3,
  parameter int unsigned GREEN_MAX  = 60,
  parameter int unsigned RED_MAX    = 120,
  parameter int unsigned DWELL_W    = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       light_M1,
  input  logic [2:0]       light_M2,
  input  logic [2:0]       light_MT,
  input  logic [2:0]       light_S,
  output logic [3:0]       err_encoding,
  output logic             err_conflict,
  output logic [3:0]       err_sequence,
  output logic [3:0]       err_timing,
  output logic             err_any,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       first_err_code,
  output logic [15:0]      cycle_count
);

  localparam int unsigned NR = 4;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [DWELL_W-1:0] DWELL_SAT = {DWELL_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_SAT   = {CNT_W{1'b1}};

  logic [2:0]         prev_col  [NR];
  logic [DWELL_W-1:0] dwell     [NR];
  logic [NR-1:0]      prev_valid;

  logic [2:0]         lights    [NR];
  logic [DWELL_W-1:0] dwell_nxt [NR];
  logic [NR-1:0]      legal, same, changed;
  logic [NR-1:0]      enc_hit, seq_hit, tim_hit;
  logic               conf_hit, cyc_hit, fire;
  logic               s_gy, main_gy, mt_m2_green;
  logic [3:0]         enc_nxt, seq_nxt, tim_nxt;
  logic               conf_nxt;
  logic [CNT_W-1:0]   cnt_base, cnt_nxt;
  logic [2:0]         code_nxt;

  // Per-road encoding, sequence and dwell evaluation against registered history
  always_comb begin
    lights[0] = light_M1;
    lights[1] = light_M2;
    lights[2] = light_MT;
    lights[3] = light_S;
    legal   = '0;
    same    = '0;
    changed = '0;
    enc_hit = '0;
    seq_hit = '0;
    tim_hit = '0;
    for (int i = 0; i < NR; i++) begin
      dwell_nxt[i] = '0;
      legal[i]   = (lights[i] == RED) || (lights[i] == YEL) || (lights[i] == GRN);
      same[i]    = legal[i] && prev_valid[i] && (lights[i] == prev_col[i]);
      changed[i] = legal[i] && prev_valid[i] && (lights[i] != prev_col[i]);
      enc_hit[i] = !legal[i];
      if (same[i])
        dwell_nxt[i] = (dwell[i] == DWELL_SAT) ? dwell[i] : dwell[i] + DWELL_W'(1);
      else if (legal[i])
        dwell_nxt[i] = DWELL_W'(1);
      seq_hit[i] = changed[i] &&
                   !((prev_col[i] == GRN && lights[i] == YEL) ||
                     (prev_col[i] == YEL && lights[i] == RED) ||
                     (prev_col[i] == RED && lights[i] == GRN));
      // Limit hits fire only on the edge where dwell first reaches the limit
      tim_hit[i] = (changed[i] && prev_col[i] == YEL && dwell[i] < DWELL_W'(YELLOW_MIN)) ||
                   (legal[i] && lights[i] == GRN && dwell_nxt[i] == DWELL_W'(GREEN_MAX) &&
                    !(same[i] && dwell[i] == DWELL_W'(GREEN_MAX))) ||
                   (legal[i] && lights[i] == RED && dwell_nxt[i] == DWELL_W'(RED_MAX) &&
                    !(same[i] && dwell[i] == DWELL_W'(RED_MAX)));
    end
  end

  // Right-of-way conflicts, M1 cycle detection and error bookkeeping
  always_comb begin
    s_gy        = legal[3] && (lights[3] != RED);
    main_gy     = (legal[0] && lights[0] != RED) || (legal[1] && lights[1] != RED) ||
                  (legal[2] && lights[2] != RED);
    mt_m2_green = legal[2] && legal[1] && (lights[2] == GRN) && (lights[1] == GRN);
    conf_hit    = (s_gy && main_gy) || mt_m2_green;
    cyc_hit     = changed[0] && (prev_col[0] == RED) && (lights[0] == GRN);
    fire        = (|enc_hit) || conf_hit || (|seq_hit) || (|tim_hit);

    enc_nxt  = (clr ? 4'b0 : err_encoding) | enc_hit;
    conf_nxt = (clr ? 1'b0 : err_conflict) | conf_hit;
    seq_nxt  = (clr ? 4'b0 : err_sequence) | seq_hit;
    tim_nxt  = (clr ? 4'b0 : err_timing)   | tim_hit;

    cnt_base = clr ? '0 : err_count;
    cnt_nxt  = cnt_base;
    if (fire && cnt_base != CNT_SAT)
      cnt_nxt = cnt_base + CNT_W'(1);

    code_nxt = clr ? 3'd0 : first_err_code;
    if (fire && cnt_base == '0) begin
      if (|enc_hit)      code_nxt = 3'd1;
      else if (conf_hit) code_nxt = 3'd2;
      else if (|seq_hit) code_nxt = 3'd3;
      else               code_nxt = 3'd4;
    end
  end

  // History and sticky error registers; everything freezes and history drops while disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_valid     <= '0;
      err_encoding   <= '0;
      err_conflict   <= 1'b0;
      err_sequence   <= '0;
      err_timing     <= '0;
      err_any        <= 1'b0;
      err_count      <= '0;
      first_err_code <= '0;
      cycle_count    <= '0;
      for (int i = 0; i < NR; i++) begin
        prev_col[i] <= '0;
        dwell[i]    <= '0;
      end
    end else if (!en) begin
      prev_valid <= '0;
      for (int i = 0; i < NR; i++) dwell[i] <= '0;
    end else begin
      prev_valid     <= legal;
      err_encoding   <= enc_nxt;
      err_conflict   <= conf_nxt;
      err_sequence   <= seq_nxt;
      err_timing     <= tim_nxt;
      err_any        <= (|enc_nxt) || conf_nxt || (|seq_nxt) || (|tim_nxt);
      err_count      <= cnt_nxt;
      first_err_code <= code_nxt;
      if (cyc_hit) cycle_count <= cycle_count + 16'd1;
      for (int i = 0; i < NR; i++) begin
        prev_col[i] <= lights[i];
        dwell[i]    <= dwell_nxt[i];
      end
    end
  end

endmodule
